// File: rtl/fsm_equiv_sequencer.sv
// rtl/fsm_equiv_sequencer.sv - side-by-side equivalence sequencer for two Moore FSMs

// 8-bit Fibonacci LFSR that produces the shared stimulus bit
module fsm_equiv_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  // Load a non-zero seed on request, otherwise advance when stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 8'h01;
    end else if (load) begin
      value <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end

endmodule

// Holds both FSMs in reset, runs them on a common stimulus and tallies mismatches
module fsm_equiv_sequencer #(
  parameter  int LEN          = 64,
  parameter  bit STOP_ON_FAIL = 1'b0,
  localparam int IDX_W        = $clog2(LEN),
  localparam int CNT_W        = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             y_a,
  input  logic             y_b,
  output logic             x,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       lfsr;
  logic [IDX_W-1:0] idx;
  logic             fail_seen;
  logic             accept;
  logic             mismatch;
  logic             finish;

  // The compare looks at the current cycle's y; both FSMs are Moore so this
  // covers their reset-state outputs at RUN index 0.
  assign mismatch = (state == S_RUN) && (y_a != y_b);
  assign finish   = (idx == LAST_IDX) || (STOP_ON_FAIL && mismatch);

  fsm_equiv_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .seed  (seed),
    .step  (state == S_RUN),
    .value (lfsr)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; start is only honoured in IDLE/DONE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dut_reset = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        dut_reset = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RST;
        end
      end
      S_RST: begin
        dut_reset = 1'b1;
        busy      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (finish) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RST;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Run index, mismatch tally and first failing index; cleared when a run is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_seen    <= 1'b0;
    end else if (accept) begin
      idx          <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_seen    <= 1'b0;
    end else if (state == S_RUN) begin
      if (mismatch) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!fail_seen) begin
          first_fail <= idx;
          fail_seen  <= 1'b1;
        end
      end
      if (!finish) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign x    = lfsr[0];
  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_fsm_equiv_sequencer.sv
// tb/tb_fsm_equiv_sequencer.sv - table-driven and randomized bench for fsm_equiv_sequencer
`timescale 1ns/1ps
module tb_fsm_equiv_sequencer;

  typedef struct {
    int          sel;
    logic [7:0]  seed;
    logic [63:0] mask;
    bit          noise;
    int          cnt;
    int          ff;
    int          n;
    bit          chk_x;
    logic [4:0]  x5;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start_v[3];
  logic [7:0] seed_v[3];
  logic       ya_v[3];
  logic       yb_v[3];
  logic       x_o[3];
  logic       dr_o[3];
  logic       busy_o[3];
  logic       done_o[3];
  logic       pass_o[3];
  int         cnt_o[3];
  int         ff_o[3];

  logic [4:0] c0, c1;
  logic [6:0] c2;
  logic [3:0] f0, f1;
  logic [5:0] f2;

  int  lens[3]  = '{16, 16, 64};
  bit  stops[3] = '{1'b0, 1'b1, 1'b0};
  int  n_vec = 0;
  int  n_bad = 0;
  vec_t tbl[5];

  always #5 clk = ~clk;

  fsm_equiv_sequencer #(.LEN(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .seed(seed_v[0]),
    .y_a(ya_v[0]), .y_b(yb_v[0]), .x(x_o[0]), .dut_reset(dr_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .mismatch_cnt(c0), .first_fail(f0));

  fsm_equiv_sequencer #(.LEN(16), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .seed(seed_v[1]),
    .y_a(ya_v[1]), .y_b(yb_v[1]), .x(x_o[1]), .dut_reset(dr_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .mismatch_cnt(c1), .first_fail(f1));

  fsm_equiv_sequencer #(.LEN(64), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .seed(seed_v[2]),
    .y_a(ya_v[2]), .y_b(yb_v[2]), .x(x_o[2]), .dut_reset(dr_o[2]),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .mismatch_cnt(c2), .first_fail(f2));

  assign cnt_o[0] = int'(c0);
  assign cnt_o[1] = int'(c1);
  assign cnt_o[2] = int'(c2);
  assign ff_o[0]  = int'(f0);
  assign ff_o[1]  = int'(f1);
  assign ff_o[2]  = int'(f2);

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next stimulus state under the polynomial x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Expected result of a run from the list of cycles whose y outputs disagree
  task automatic model(input int len, input bit stop, input logic [63:0] mask,
                       output int cnt, output int ff, output int n);
    cnt = 0;
    ff  = 0;
    n   = len;
    for (int k = 0; k < len; k++) begin
      if (mask[k]) begin
        if (cnt == 0) ff = k;
        cnt++;
        if (stop) begin
          n = k + 1;
          break;
        end
      end
    end
  endtask

  task automatic run(input vec_t v);
    logic [7:0] lf;
    int s;
    s = v.sel;
    @(negedge clk);
    seed_v[s]  = v.seed;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("rst_busy", int'(busy_o[s]), 1);
    chk("rst_dut_reset", int'(dr_o[s]), 1);
    chk("rst_done", int'(done_o[s]), 0);
    chk("rst_cnt_clear", cnt_o[s], 0);
    chk("rst_ff_clear", ff_o[s], 0);
    lf = (v.seed == 8'h00) ? 8'h01 : v.seed;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      chk("run_busy", int'(busy_o[s]), 1);
      chk("run_dut_reset", int'(dr_o[s]), 0);
      chk("run_done", int'(done_o[s]), 0);
      chk("run_x", int'(x_o[s]), int'(lf[0]));
      if (v.chk_x && k < 5) chk("run_x_const", int'(x_o[s]), int'(v.x5[k]));
      ya_v[s]    = 1'($urandom_range(0, 1));
      yb_v[s]    = ya_v[s] ^ v.mask[k];
      start_v[s] = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      lf = lfsr_next(lf);
    end
    @(negedge clk);
    start_v[s] = 1'b0;
    ya_v[s]    = 1'b0;
    yb_v[s]    = 1'b0;
    chk("done_done", int'(done_o[s]), 1);
    chk("done_busy", int'(busy_o[s]), 0);
    chk("done_dut_reset", int'(dr_o[s]), 0);
    chk("done_pass", int'(pass_o[s]), (v.cnt == 0) ? 1 : 0);
    chk("done_cnt", cnt_o[s], v.cnt);
    chk("done_first_fail", ff_o[s], v.ff);
    chk("done_x", int'(x_o[s]), int'(lf[0]));
    @(negedge clk);
    chk("hold_done", int'(done_o[s]), 1);
    chk("hold_cnt", cnt_o[s], v.cnt);
    chk("hold_x", int'(x_o[s]), int'(lf[0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      seed_v[i]  = 8'h00;
      ya_v[i]    = 1'b0;
      yb_v[i]    = 1'b0;
    end
    tbl[0] = '{0, 8'h01, 64'h0,             1'b0, 0, 0, 16, 1'b1, 5'b10001};
    tbl[1] = '{0, 8'h5A, 64'h20,            1'b0, 1, 5, 16, 1'b0, 5'b00000};
    tbl[2] = '{1, 8'h37, {64{1'b1}},        1'b0, 1, 0, 1,  1'b0, 5'b00000};
    tbl[3] = '{0, 8'h00, 64'h0,             1'b1, 0, 0, 16, 1'b1, 5'b10001};
    tbl[4] = '{2, 8'hC3, 64'h418,           1'b0, 3, 3, 64, 1'b0, 5'b00000};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_x", int'(x_o[i]), 1);
      chk("reset_dut_reset", int'(dr_o[i]), 1);
      chk("reset_busy", int'(busy_o[i]), 0);
      chk("reset_done", int'(done_o[i]), 0);
      chk("reset_pass", int'(pass_o[i]), 0);
      chk("reset_cnt", cnt_o[i], 0);
      chk("reset_ff", ff_o[i], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Asynchronous reset in the middle of RUN, away from any clock edge
    @(negedge clk);
    seed_v[0]  = 8'h01;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ya_v[0] = 1'b0;
      yb_v[0] = (k == 2);
    end
    chk("mid_cnt_before", cnt_o[0], 1);
    chk("mid_busy_before", int'(busy_o[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_dut_reset", int'(dr_o[0]), 1);
    chk("async_busy", int'(busy_o[0]), 0);
    chk("async_done", int'(done_o[0]), 0);
    chk("async_cnt", cnt_o[0], 0);
    chk("async_ff", ff_o[0], 0);
    chk("async_x", int'(x_o[0]), 1);
    yb_v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run(tbl[0]);

    // Randomized runs checked against the result model
    for (int r = 0; r < 12; r++) begin
      v.sel   = $urandom_range(0, 2);
      v.seed  = 8'($urandom_range(0, 255));
      v.noise = 1'($urandom_range(0, 1));
      v.chk_x = 1'b0;
      v.x5    = 5'b00000;
      v.mask  = '0;
      for (int k = 0; k < 64; k++) v.mask[k] = ($urandom_range(0, 7) == 0);
      model(lens[v.sel], stops[v.sel], v.mask, v.cnt, v.ff, v.n);
      run(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_equiv_sequencer.md
Name: fsm_equiv_sequencer

Overview:
Test sequencer that runs two candidate Moore FSMs side by side: an original state machine and its state-reduced equivalent.
- Holds both FSMs in reset, then releases them together.
- Drives a shared pseudo-random input bit `x` for LEN cycles.
- Compares their `y` outputs every cycle and reports pass/fail, mismatch count and the first failing cycle.
- Sits above the FSM pair in the activity top level and runs on the board clock.

Parameters:
- LEN, 64: number of compared RUN cycles (≥2).
- STOP_ON_FAIL, 0: 1 = terminate the run on the first mismatch.
- IDX_W, $clog2(LEN): width of cycle index and first_fail (localparam).
- CNT_W, $clog2(LEN+1): width of mismatch_cnt (localparam).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run (sampled in IDLE or DONE only).
- seed  in  8  LFSR seed, captured when start is accepted.
- y_a  in  1  output of the original FSM.
- y_b  in  1  output of the reduced FSM.
- x  out  1  shared stimulus bit to both FSMs.
- dut_reset  out  1  reset to both FSMs, active-high.
- busy  out  1  high in RST and RUN.
- done  out  1  high while in DONE.
- pass  out  1  valid when done: 1 iff mismatch_cnt == 0.
- mismatch_cnt  out  CNT_W  number of RUN cycles with y_a != y_b.
- first_fail  out  IDX_W  RUN index of the first mismatch; 0 if none.

Behaviour:
- States: IDLE, RST, RUN, DONE.
- Async reset (any time, including mid-run):
  - state = IDLE; lfsr = 8'h01; idx = 0.
  - mismatch_cnt = 0, first_fail = 0, fail_seen = 0.
  - Outputs: x = 1 (lfsr[0]), dut_reset = 1, busy = 0, done = 0, pass = 0.
- IDLE: dut_reset = 1.
  - start → RST.
  - On that edge: lfsr <= (seed == 0) ? 8'h01 : seed; clear mismatch_cnt, first_fail, fail_seen, idx.
- RST: exactly one cycle; dut_reset = 1; → RUN.
- RUN: dut_reset = 0; x = lfsr[0] (combinational from the register).
  - Each edge: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - y_a/y_b are sampled on the same edge that advances idx.
  - If y_a != y_b:
    - mismatch_cnt += 1.
    - If !fail_seen: first_fail <= idx and fail_seen <= 1.
  - Exit to DONE when idx == LEN-1, or on a mismatch when STOP_ON_FAIL = 1.
  - Otherwise idx += 1.
- DONE:
  - done = 1, pass = (mismatch_cnt == 0), dut_reset = 0; x holds lfsr[0].
  - All result registers hold their values.
  - start → RST with the same capture/clear as in IDLE.
- start in RST or RUN is ignored.
- Latency: start accepted at edge T0 → RST during T0..T1 → RUN compares LEN cycles → done high from edge T0+1+LEN (full run).
- Compare is on the current cycle's y.
  - The FSMs are Moore with y decoded from state, and were reset to their initial state in RST.
  - RUN idx 0 therefore compares both initial-state outputs.
- mismatch_cnt cannot overflow: CNT_W covers LEN.
- Outputs are derived from registered state and registers only, with no combinational path from start or y_* to any output.

Test Plan:
1. Identical FSMs: y_b tied to y_a, LEN=16, seed=8'h01, start pulse → x over RUN idx 0..4 = 1,0,0,0,1; busy for 17 cycles; done=1, pass=1, mismatch_cnt=0, first_fail=0.
2. Single mismatch: y_b = ~y_a only at RUN idx 5, LEN=16 → done after 17 cycles; mismatch_cnt=1, first_fail=5, pass=0.
3. STOP_ON_FAIL=1, y_b = ~y_a permanently → DONE after RUN idx 0 (busy for 2 cycles); mismatch_cnt=1, first_fail=0, pass=0.
4. seed=8'h00 → x sequence identical to seed 8'h01 (1,0,0,0,1); start pulses during RUN do not restart the run; start in DONE restarts and clears all counters.
5. Async reset asserted mid-RUN (idx=7), independent of the clock edge → immediately state IDLE, dut_reset=1, busy=0, done=0, mismatch_cnt=0, first_fail=0; a new start behaves as in scenario 1.
6. Multiple mismatches at idx 3, 4 and 10, LEN=64 → mismatch_cnt=3, first_fail=3, done at T0+65.
